// File: rtl/hash_host_if_if.sv
`default_nettype none
// ==========================================================================
// hash_host_if_if : host-bus and hash-core signal bundle for hash_host_if
// Rev 1.0
// ==========================================================================
interface hash_host_if_if #(
  parameter int BUS_W     = 16,
  parameter int WORD_W    = 32,
  parameter int DIG_WORDS = 8
);
  // host side
  logic                        init;
  logic                        load;
  logic                        fetch;
  logic [BUS_W-1:0]            idata;
  logic                        ready;
  logic                        ack;
  logic [BUS_W-1:0]            odata;
  logic                        err;
  // core side
  logic                        core_init;
  logic                        core_en;
  logic [WORD_W-1:0]           core_word;
  logic                        core_last;
  logic                        core_done;
  logic [DIG_WORDS*WORD_W-1:0] digest;

  modport slave (
    input  init, load, fetch, idata, core_done, digest,
    output ready, ack, odata, err, core_init, core_en, core_word, core_last
  );

  modport master (
    output init, load, fetch, idata, core_done, digest,
    input  ready, ack, odata, err, core_init, core_en, core_word, core_last
  );
endinterface
`default_nettype wire

// File: rtl/hash_host_if.sv
`default_nettype none
// ==========================================================================
// hash_host_if : packs host chunks into core words, tags block ends and
//                serialises the digest back to the host in bus-width chunks
// Rev 1.0
// ==========================================================================
module hash_host_if #(
  parameter int BUS_W     = 16,
  parameter int WORD_W    = 32,
  parameter int BLK_WORDS = 16,
  parameter int DIG_WORDS = 8,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  hash_host_if_if.slave bus
);
  localparam int R      = WORD_W / BUS_W;
  localparam int NCHUNK = DIG_WORDS * R;
  localparam int NB     = BUS_W / 8;
  localparam int CW     = (R > 1) ? $clog2(R) : 1;
  localparam int WW     = $clog2(BLK_WORDS);
  localparam int OW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(R - 1);
  localparam logic [WW-1:0] W_LAST = WW'(BLK_WORDS - 1);
  localparam logic [OW-1:0] O_LAST = OW'(NCHUNK - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_INIT  = 3'd5
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       ccnt_q;
  logic [WW-1:0]       wcnt_q;
  logic [OW-1:0]       ocnt_q;
  logic [WORD_W-1:0]   asm_q;
  logic [WORD_W-1:0]   asm_d;
  logic                dig_ok_q;
  logic                err_q;
  logic                ack_q;
  logic [BUS_W-1:0]    odata_q;
  logic                core_init_q;
  logic                core_en_q;
  logic [WORD_W-1:0]   core_word_q;
  logic                core_last_q;

  logic [BUS_W-1:0]    w_chunk_in;
  logic [BUS_W-1:0]    w_dig_chunk;
  logic [BUS_W-1:0]    w_chunk_out;
  logic                w_req_any;
  logic                w_init_acc;

  function automatic logic [BUS_W-1:0] swap_bytes(input logic [BUS_W-1:0] x);
    logic [BUS_W-1:0] y;
    y = '0;
    for (int b = 0; b < NB; b++) begin
      y[b*8 +: 8] = x[(NB-1-b)*8 +: 8];
    end
    return y;
  endfunction

  assign w_dig_chunk = bus.digest[int'(ocnt_q)*BUS_W +: BUS_W];

  generate
    if (BYTE_SWAP) begin : g_swap
      assign w_chunk_in  = swap_bytes(bus.idata);
      assign w_chunk_out = swap_bytes(w_dig_chunk);
    end else begin : g_noswap
      assign w_chunk_in  = bus.idata;
      assign w_chunk_out = w_dig_chunk;
    end
  endgenerate

  // New chunks enter at the top so the first chunk of a word drifts to the low end.
  generate
    if (R == 1) begin : g_asm_single
      assign asm_d = w_chunk_in;
    end else begin : g_asm_shift
      assign asm_d = {w_chunk_in, asm_q[WORD_W-1:BUS_W]};
    end
  endgenerate

  assign w_req_any  = bus.init | bus.load | bus.fetch;
  assign w_init_acc = bus.init & ((state_q == S_IDLE) | (state_q == S_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ccnt_q      <= '0;
      wcnt_q      <= '0;
      ocnt_q      <= '0;
      asm_q       <= '0;
      dig_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      odata_q     <= '0;
      core_init_q <= 1'b0;
      core_en_q   <= 1'b0;
      core_word_q <= '0;
      core_last_q <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      core_init_q <= 1'b0;
      core_en_q   <= 1'b0;
      core_last_q <= 1'b0;

      if (w_init_acc) begin
        // init wins over everything, including an in-flight block in WAIT
        ccnt_q      <= '0;
        wcnt_q      <= '0;
        ocnt_q      <= '0;
        asm_q       <= '0;
        dig_ok_q    <= 1'b0;
        err_q       <= 1'b0;
        core_init_q <= 1'b1;
        state_q     <= S_INIT;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.load) begin
              if (bus.fetch) err_q <= 1'b1;
              if ((ccnt_q == '0) && (wcnt_q == '0)) dig_ok_q <= 1'b0;
              asm_q   <= asm_d;
              ccnt_q  <= (ccnt_q == C_LAST) ? '0 : ccnt_q + 1'b1;
              ocnt_q  <= '0;
              ack_q   <= 1'b1;
              state_q <= S_LOAD;
            end else if (bus.fetch) begin
              if (dig_ok_q) begin
                odata_q <= w_chunk_out;
                ocnt_q  <= (ocnt_q == O_LAST) ? '0 : ocnt_q + 1'b1;
                ack_q   <= 1'b1;
                state_q <= S_READ;
              end else begin
                err_q <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            if (w_req_any) err_q <= 1'b1;
            // ccnt just wrapped: the assembly register holds a complete word
            if (ccnt_q == '0) begin
              core_en_q   <= 1'b1;
              core_word_q <= asm_q;
              core_last_q <= (wcnt_q == W_LAST);
              wcnt_q      <= (wcnt_q == W_LAST) ? '0 : wcnt_q + 1'b1;
              state_q     <= S_ISSUE;
            end else begin
              state_q <= S_IDLE;
            end
          end

          S_ISSUE: begin
            if (w_req_any) err_q <= 1'b1;
            state_q <= core_last_q ? S_WAIT : S_IDLE;
          end

          S_WAIT: begin
            if (w_req_any) err_q <= 1'b1;
            if (bus.core_done) begin
              dig_ok_q <= 1'b1;
              state_q  <= S_IDLE;
            end
          end

          default: begin
            if (w_req_any) err_q <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.ack       = ack_q;
  assign bus.odata     = odata_q;
  assign bus.err       = err_q;
  assign bus.core_init = core_init_q;
  assign bus.core_en   = core_en_q;
  assign bus.core_word = core_word_q;
  assign bus.core_last = core_last_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_host_if.sv
`default_nettype none
// ==========================================================================
// tb_hash_host_if : random scoreboard bench for hash_host_if, checked against
//                   a chunk-level reference model
// Rev 1.0
// ==========================================================================
module tb_hash_host_if;
  localparam int BUS_W  = 16;
  localparam int WORD_W = 32;
  localparam int BLK    = 16;
  localparam int DW     = 8;
  localparam int R      = WORD_W / BUS_W;
  localparam int NCH    = DW * R;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_host_if_if #(.BUS_W(BUS_W), .WORD_W(WORD_W), .DIG_WORDS(DW)) bus ();
  hash_host_if #(.BUS_W(BUS_W), .WORD_W(WORD_W), .BLK_WORDS(BLK), .DIG_WORDS(DW),
                 .BYTE_SWAP(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  hash_host_if_if #(.BUS_W(8), .WORD_W(64), .DIG_WORDS(1)) bus2 ();
  hash_host_if #(.BUS_W(8), .WORD_W(64), .BLK_WORDS(2), .DIG_WORDS(1),
                 .BYTE_SWAP(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [BUS_W-1:0]  m_chunks[$];
  int                m_widx, m_ocnt;
  bit                m_dig_ok, m_err, m_wait;
  logic [BUS_W-1:0]  m_odata;
  logic [WORD_W-1:0] m_dig[DW];
  logic [BUS_W-1:0]  exp_ack[$];
  logic [WORD_W:0]   exp_core[$];   // {last, word}
  int                exp_inits = 0;
  int                obs_inits = 0;

  function automatic logic [BUS_W-1:0] swapb(input logic [BUS_W-1:0] x);
    logic [BUS_W-1:0] y;
    y = '0;
    for (int b = 0; b < BUS_W/8; b++) y[b*8 +: 8] = x[BUS_W-8-b*8 +: 8];
    return y;
  endfunction

  function automatic void model_reset();
    m_chunks.delete();
    m_widx = 0; m_ocnt = 0; m_dig_ok = 0; m_err = 0; m_wait = 0; m_odata = '0;
  endfunction

  function automatic void model_init();
    m_chunks.delete();
    m_widx = 0; m_ocnt = 0; m_dig_ok = 0; m_err = 0; m_wait = 0;
    exp_inits++;
  endfunction

  function automatic void model_load(input logic [BUS_W-1:0] d);
    logic [WORD_W-1:0] w;
    if (m_chunks.size() == 0 && m_widx == 0) m_dig_ok = 0;
    m_ocnt = 0;
    m_chunks.push_back(swapb(d));
    exp_ack.push_back(m_odata);
    if (m_chunks.size() == R) begin
      w = '0;
      for (int k = 0; k < R; k++) w = w | (WORD_W'(m_chunks[k]) << (k*BUS_W));
      exp_core.push_back({(m_widx == BLK-1), w});
      m_wait = (m_widx == BLK-1);
      m_widx = (m_widx + 1) % BLK;
      m_chunks.delete();
    end
  endfunction

  function automatic void model_fetch();
    if (m_dig_ok) begin
      m_odata = swapb(BUS_W'(m_dig[m_ocnt / R] >> ((m_ocnt % R) * BUS_W)));
      exp_ack.push_back(m_odata);
      m_ocnt = (m_ocnt + 1) % NCH;
    end else begin
      m_err = 1;
    end
  endfunction

  function automatic void model_req(input bit i, input bit l, input bit f,
                                    input logic [BUS_W-1:0] d);
    if (i) model_init();
    else if (l) begin
      model_load(d);
      if (f) m_err = 1;
    end else if (f) model_fetch();
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [BUS_W-1:0] ea;
    logic [WORD_W:0]  ec;
    if (!rst) begin
      if (bus.ack) begin
        if (exp_ack.size() == 0) check("ack_spurious", bus.ack, 0);
        else begin
          ea = exp_ack.pop_front();
          check("ack_odata", bus.odata, ea);
        end
      end
      if (bus.core_en) begin
        if (exp_core.size() == 0) check("core_en_spurious", bus.core_en, 0);
        else begin
          ec = exp_core.pop_front();
          check("core_word", bus.core_word, ec[WORD_W-1:0]);
          check("core_last", bus.core_last, ec[WORD_W]);
        end
      end else if (bus.core_last) begin
        check("core_last_alone", bus.core_last, 0);
      end
      if (bus.core_init) obs_inits++;
    end
  end

  logic [63:0] exp2 = '0;
  int          n2_seen = 0;
  always @(negedge clk) begin
    if (!rst && bus2.core_en) begin
      check("core_word_w64", bus2.core_word, exp2);
      n2_seen++;
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.ready, 1);
  endtask

  task automatic pulse(input bit i, input bit l, input bit f, input bit cd,
                       input logic [BUS_W-1:0] d);
    bus.init = i; bus.load = l; bus.fetch = f; bus.core_done = cd; bus.idata = d;
    @(posedge clk);
    #1;
    bus.init = 0; bus.load = 0; bus.fetch = 0; bus.core_done = 0;
  endtask

  task automatic send(input bit i, input bit l, input bit f, input logic [BUS_W-1:0] d);
    wait_ready();
    pulse(i, l, f, 1'b0, d);
    model_req(i, l, f, d);
    check("err", bus.err, m_err);
  endtask

  task automatic block_done(input bit violate, input bit abort, input logic [WORD_W-1:0] w0);
    repeat (4) @(negedge clk);
    check("wait_ready_low", bus.ready, 0);
    if (violate) begin
      pulse(0, 0, 1, 0, '0);
      m_err = 1;
      check("err_fetch_in_wait", bus.err, 1);
      @(negedge clk);
      pulse(0, 1, 0, 0, 16'hDEAD);
      check("err_load_in_wait", bus.err, 1);
      @(negedge clk);
    end
    if (abort) begin
      pulse(1, 0, 0, 0, '0);
      model_init();
    end else begin
      m_dig[0] = w0;
      for (int k = 1; k < DW; k++) m_dig[k] = $urandom;
      for (int k = 0; k < DW; k++) bus.digest[k*WORD_W +: WORD_W] = m_dig[k];
      pulse(0, 0, 0, 1, '0);
      m_dig_ok = 1;
      m_wait   = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    bus.init = 0; bus.load = 0; bus.fetch = 0; bus.core_done = 0; bus.idata = '0;
    bus.digest = '0;
    bus2.init = 0; bus2.load = 0; bus2.fetch = 0; bus2.core_done = 0; bus2.idata = '0;
    bus2.digest = '0;
    model_reset();

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_core_en", bus.core_en, 0);
    check("rst_core_init", bus.core_init, 0);
    check("rst_core_last", bus.core_last, 0);
    check("rst_core_word", bus.core_word, 0);
    check("rst_odata", bus.odata, 0);
    rst = 0;

    // fetch with no digest yet, then init clears err
    send(0, 0, 1, '0);
    send(1, 0, 0, '0);

    // default message: 32 loads, WAIT held, violations, then digest readout
    for (int i = 0; i < 32; i++) send(0, 1, 0, 16'h0100 + 16'(i));
    block_done(1'b1, 1'b0, 32'hAABBCCDD);
    for (int i = 0; i < 17; i++) send(0, 0, 1, '0);
    send(1, 0, 0, '0);

    // simultaneous requests
    send(0, 1, 1, 16'h1234);
    send(1, 1, 0, 16'h5555);

    // rst after 3 chunks discards the partial word
    send(0, 1, 0, 16'hE001);
    send(0, 1, 0, 16'hE002);
    send(0, 1, 0, 16'hE003);
    wait_ready();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check("post_rst_odata", bus.odata, 0);
    check("post_rst_err", bus.err, 0);
    send(0, 1, 0, 16'hF001);
    send(0, 1, 0, 16'hF002);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      send(0, 1, 0, 16'($urandom));
      else if (r < 85) send(0, 0, 1, '0);
      else if (r < 88) send(1, 0, 0, '0);
      else if (r < 94) begin
        wait_ready();
        pulse(0, 0, 0, 1, '0);
        check("err_after_stray_done", bus.err, m_err);
      end else send(1'($urandom), 1'b1, 1'($urandom), 16'($urandom));
      if (m_wait) block_done(($urandom % 4) == 0, ($urandom % 6) == 0, $urandom);
    end

    // 64-bit word, 8-bit bus, no swap
    for (int k = 1; k <= 8; k++) exp2 = exp2 | (64'(k) << (8*(k-1)));
    for (int k = 1; k <= 8; k++) begin
      int n = 0;
      @(negedge clk);
      while (!bus2.ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("ready2_wait", bus2.ready, 1);
      bus2.load = 1; bus2.idata = 8'(k);
      @(posedge clk);
      #1;
      bus2.load = 0;
    end

    repeat (6) @(negedge clk);
    check("w64_issue_count", n2_seen, 1);
    check("ack_queue_drained", exp_ack.size(), 0);
    check("core_queue_drained", exp_core.size(), 0);
    check("core_init_count", obs_inits, exp_inits);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
